// File: rtl/ht_budget_unit.sv
// ht_budget_unit
// Holds the per-ID head/tail table for the AXI read/write guard. From the table it derives
// the free-entry vector, the lowest free index and a full flag. Separately, it sums the
// outstanding beats (len+1) over every occupied linked-data entry.
// Build option: define HT_BUDGET_SAT_EN to saturate accum_burst_len_o at its maximum
// value. Without it, the sum wraps modulo 2^AccuCntWidth.
module ht_budget_unit #(
  parameter int HtCapacity   = 8,
  parameter int MaxTxns      = 8,
  parameter int IdWidth      = 4,
  parameter int LdIdxWidth   = (MaxTxns > 1) ? $clog2(MaxTxns) : 1,
  parameter int LenWidth     = 8,
  parameter int AccuCntWidth = 16,
  localparam int EntryW      = IdWidth + 2*LdIdxWidth + 1,
  localparam int HtIdxW      = (HtCapacity > 1) ? $clog2(HtCapacity) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [HtCapacity-1:0]          ht_we_i,
  input  logic [HtCapacity*EntryW-1:0]   ht_d_i,
  output logic [HtCapacity*EntryW-1:0]   ht_q_o,
  output logic [HtCapacity-1:0]          ht_free_o,
  output logic [HtIdxW-1:0]              ht_free_idx_o,
  output logic                           ht_full_o,
  input  logic [MaxTxns-1:0]             ld_free_i,
  input  logic [MaxTxns*LenWidth-1:0]    ld_len_i,
  output logic [AccuCntWidth-1:0]        accum_burst_len_o
);

  // The saturating build needs headroom above the output width to detect overflow.
  // The wrapping build simply accumulates at the output width.
`ifdef HT_BUDGET_SAT_EN
  localparam int SumW = AccuCntWidth + LenWidth + $clog2(MaxTxns + 1) + 1;
`else
  localparam int SumW = AccuCntWidth;
`endif

  // Reset image of an entry: id/head/tail cleared, free bit (LSB) set.
  localparam logic [EntryW-1:0] EntryRst = EntryW'(1);

  logic [EntryW-1:0] ht_tbl_p1 [HtCapacity];
  logic [SumW-1:0]   beat_sum;

  // Reduce the wide beat sum to the output width.
  function automatic logic [AccuCntWidth-1:0] fit_sum(input logic [SumW-1:0] s);
`ifdef HT_BUDGET_SAT_EN
    if (|s[SumW-1:AccuCntWidth]) return '1;
    return s[AccuCntWidth-1:0];
`else
    return s;
`endif
  endfunction

  // ---- stage p1: table registers, independently written per entry ----
  // Per-entry table storage: load on its own enable, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < HtCapacity; i++) ht_tbl_p1[i] <= EntryRst;
    end else begin
      for (int i = 0; i < HtCapacity; i++)
        if (ht_we_i[i]) ht_tbl_p1[i] <= ht_d_i[i*EntryW +: EntryW];
    end
  end

  for (genvar g = 0; g < HtCapacity; g++) begin : g_q
    assign ht_q_o[g*EntryW +: EntryW] = ht_tbl_p1[g];
    assign ht_free_o[g]               = ht_tbl_p1[g][0];
  end

  // Lowest free entry. The scan runs from the top down, so the smallest hit wins.
  // Index stays 0 when no entry is free.
  always_comb begin
    ht_free_idx_o = '0;
    ht_full_o     = 1'b1;
    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (ht_tbl_p1[i][0]) begin
        ht_free_idx_o = HtIdxW'(i);
        ht_full_o     = 1'b0;
      end
    end
  end

  // Outstanding beats: each occupied linked-data entry contributes len+1.
  always_comb begin
    beat_sum = '0;
    for (int j = 0; j < MaxTxns; j++)
      if (!ld_free_i[j])
        beat_sum = beat_sum + SumW'(ld_len_i[j*LenWidth +: LenWidth]) + SumW'(1);
  end

  assign accum_burst_len_o = fit_sum(beat_sum);

endmodule

// File: tb/tb_ht_budget_unit.sv
// Bench for ht_budget_unit. It runs a default-width instance alongside an 8-bit
// accumulator instance, which exposes overflow. Both are checked against a reference
// model that lives in the bench.
module tb_ht_budget_unit;
  localparam int HC = 8, MT = 8, IW = 4, LW = 3, LENW = 8;
  localparam int EW = IW + 2*LW + 1;

  logic             clk, rst_i;
  logic [HC-1:0]    ht_we_i;
  logic [HC*EW-1:0] ht_d_i, ht_q_o, ht_q8;
  logic [HC-1:0]    ht_free_o, ht_free8;
  logic [2:0]       ht_free_idx_o, idx8;
  logic             ht_full_o, full8;
  logic [MT-1:0]    ld_free_i;
  logic [MT*LENW-1:0] ld_len_i;
  logic [15:0]      accum16;
  logic [7:0]       accum8;

  int ncmp = 0;
  int nfail = 0;
  logic [EW-1:0] mdl [HC];

  ht_budget_unit #(.HtCapacity(HC), .MaxTxns(MT), .IdWidth(IW), .LenWidth(LENW),
                   .AccuCntWidth(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .ht_we_i(ht_we_i), .ht_d_i(ht_d_i), .ht_q_o(ht_q_o),
    .ht_free_o(ht_free_o), .ht_free_idx_o(ht_free_idx_o), .ht_full_o(ht_full_o),
    .ld_free_i(ld_free_i), .ld_len_i(ld_len_i), .accum_burst_len_o(accum16));

  ht_budget_unit #(.HtCapacity(HC), .MaxTxns(MT), .IdWidth(IW), .LenWidth(LENW),
                   .AccuCntWidth(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .ht_we_i(ht_we_i), .ht_d_i(ht_d_i), .ht_q_o(ht_q8),
    .ht_free_o(ht_free8), .ht_free_idx_o(idx8), .ht_full_o(full8),
    .ld_free_i(ld_free_i), .ld_len_i(ld_len_i), .accum_burst_len_o(accum8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] pack(input int id, input int head, input int tail,
                                         input bit free);
    logic [IW-1:0] i4;
    logic [LW-1:0] h3, t3;
    i4 = IW'(id);
    h3 = LW'(head);
    t3 = LW'(tail);
    return {i4, h3, t3, free};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both instances' table outputs with the model.
  // Expected free/idx/full are found by searching the model table.
  task automatic check_table(input string tag);
    logic [HC-1:0] exp_free;
    int exp_idx;
    bit found;
    exp_free = '0;
    exp_idx = 0;
    found = 0;
    for (int i = 0; i < HC; i++) begin
      exp_free[i] = mdl[i][0];
      if (mdl[i][0] && !found) begin
        exp_idx = i;
        found = 1;
      end
      check($sformatf("%s q[%0d]", tag, i), 64'(ht_q_o[i*EW +: EW]), 64'(mdl[i]));
      check($sformatf("%s q8[%0d]", tag, i), 64'(ht_q8[i*EW +: EW]), 64'(mdl[i]));
    end
    check({tag, " free"}, 64'(ht_free_o), 64'(exp_free));
    check({tag, " free8"}, 64'(ht_free8), 64'(exp_free));
    check({tag, " idx"}, 64'(ht_free_idx_o), 64'(exp_idx));
    check({tag, " idx8"}, 64'(idx8), 64'(exp_idx));
    check({tag, " full"}, 64'(ht_full_o), 64'(!found));
    check({tag, " full8"}, 64'(full8), 64'(!found));
  endtask

  task automatic check_budget(input string tag);
    int sum;
    int exp8;
    sum = 0;
    for (int j = 0; j < MT; j++)
      if (!ld_free_i[j]) sum += int'(ld_len_i[j*LENW +: LENW]) + 1;
`ifdef HT_BUDGET_SAT_EN
    exp8 = (sum > 255) ? 255 : sum;
`else
    exp8 = sum % 256;
`endif
    check({tag, " acc16"}, 64'(accum16), 64'(sum % 65536));
    check({tag, " acc8"}, 64'(accum8), 64'(exp8));
  endtask

  // Apply one write cycle and update the model after the edge.
  task automatic write(input logic [HC-1:0] we, input logic [HC*EW-1:0] d);
    ht_we_i = we;
    ht_d_i  = d;
    @(posedge clk);
    #1;
    for (int i = 0; i < HC; i++)
      if (we[i]) mdl[i] = d[i*EW +: EW];
    ht_we_i = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < HC; i++) mdl[i] = pack(0, 0, 0, 1'b1);
  endtask

  initial begin
    logic [HC*EW-1:0] d;
    int exp_sat;

    rst_i = 1'b1;
    ht_we_i = '0;
    ht_d_i = '0;
    ld_free_i = '1;
    ld_len_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_table("reset_hold");
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    check_table("reset_idle");

    // Allocate entries 0 then 1.
    d = '0;
    d[0*EW +: EW] = pack(3, 2, 2, 1'b0);
    write(8'h01, d);
    check_table("wr_e0");
    check("idx_after_e0", 64'(ht_free_idx_o), 64'd1);
    d[1*EW +: EW] = pack(5, 1, 4, 1'b0);
    write(8'h02, d);
    check_table("wr_e1");
    check("idx_after_e1", 64'(ht_free_idx_o), 64'd2);

    // Fill the table, then release entry 5.
    for (int i = 0; i < HC; i++) d[i*EW +: EW] = pack(i + 1, i, 7 - i, 1'b0);
    write('1, d);
    check_table("full");
    check("full_flag", 64'(ht_full_o), 64'd1);
    d[5*EW +: EW] = pack(0, 0, 0, 1'b1);
    write(8'h20, d);
    check_table("free5");
    check("idx_free5", 64'(ht_free_idx_o), 64'd5);

    // Random writes with arbitrary enable combinations.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < HC; i++) d[i*EW +: EW] = EW'($urandom);
      write(HC'($urandom), d);
      check_table($sformatf("rnd_wr%0d", n));
    end

    // Budget: directed cases.
    for (int j = 0; j < MT; j++) ld_len_i[j*LENW +: LENW] = LENW'($urandom);
    ld_len_i[0*LENW +: LENW] = 8'd3;
    ld_len_i[2*LENW +: LENW] = 8'd15;
    ld_free_i = 8'b1111_1010;
    #1;
    check("budget_20", 64'(accum16), 64'd20);
    check_budget("budget_dir");
    ld_free_i = '1;
    #1;
    check("budget_allfree", 64'(accum16), 64'd0);
    check_budget("budget_free");
    ld_free_i = '0;
    ld_len_i = '1;
    #1;
    check("budget_2048", 64'(accum16), 64'd2048);
`ifdef HT_BUDGET_SAT_EN
    exp_sat = 255;
`else
    exp_sat = 0;
`endif
    check("budget_ovf8", 64'(accum8), 64'(exp_sat));
    check_budget("budget_max");
    for (int n = 0; n < 30; n++) begin
      ld_free_i = MT'($urandom);
      for (int j = 0; j < MT; j++) ld_len_i[j*LENW +: LENW] = LENW'($urandom);
      #1;
      check_budget($sformatf("budget_rnd%0d", n));
    end

    // Asynchronous reset mid-cycle with a competing write.
    @(posedge clk);
    #1;
    for (int i = 0; i < HC; i++) d[i*EW +: EW] = pack(i + 2, i, i, 1'b0);
    write('1, d);
    check_table("pre_rst");
    #3;
    rst_i = 1'b1;
    ht_we_i = '1;
    for (int i = 0; i < HC; i++) ht_d_i[i*EW +: EW] = pack(9, 3, 3, 1'b0);
    #1;
    model_reset();
    check_table("async_rst");
    @(posedge clk);
    #1;
    check_table("rst_we_ignored");
    rst_i = 1'b0;
    ht_we_i = '0;
    @(posedge clk);
    #1;
    check_table("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
